dma_hold_arbiter: RTL and testbench

DMA_HOLD_ARBITER -- requirements
Module: dma_hold_arbiter

---
 rtl/dma_hold_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_dma_hold_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_hold_arbiter.sv
// Hold arbiter between a DMA controller's HRQ/HLDA handshake and the CPU bus unit.
// Optional sticky grant-length watchdog built only when DMA_HOLD_TIMEOUT_EN is defined.
module dma_hold_arbiter #(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned RELEASE_CYCLES = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic CLK,
    input  logic RESET,
    input  logic HRQ,
    input  logic CPU_HOLDACK,
    input  logic CPU_LOCK,
    output logic HLDA,
    output logic CPU_HOLD,
    output logic AEN,
    output logic TIMEOUT
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_GRANT   = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // Settle exits on the edge where the counter is already zero, so it loads one less.
    localparam logic [3:0] SETTLE_LOAD  = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] RELEASE_LOAD = 4'(RELEASE_CYCLES);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       r_hlda;
    logic       r_cpu_hold;
    logic       r_aen;
    logic       w_hlda_d;
    logic       w_cpu_hold_d;
    logic       w_aen_d;

    // State, phase counter and output registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_hlda     <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_aen      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_cnt_next;
            r_hlda     <= w_hlda_d;
            r_cpu_hold <= w_cpu_hold_d;
            r_aen      <= w_aen_d;
        end
    end

    // Next-state and counter logic; CPU_LOCK only gates the IDLE exit.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = 4'd0;
                if (HRQ && !CPU_LOCK && !CPU_HOLDACK) begin
                    w_next_state = ST_REQ;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!HRQ) begin
                    if (CPU_HOLDACK) begin
                        w_next_state = ST_RELEASE;
                        w_cnt_next   = RELEASE_LOAD;
                    end else begin
                        w_next_state = ST_IDLE;
                        w_cnt_next   = 4'd0;
                    end
                end else if (CPU_HOLDACK) begin
                    w_next_state = ST_SETTLE;
                    w_cnt_next   = SETTLE_LOAD;
                end else begin
                    w_next_state = ST_REQ;
                end
            end
            ST_SETTLE: begin
                if (!HRQ) begin
                    w_next_state = ST_RELEASE;
                    w_cnt_next   = RELEASE_LOAD;
                end else if (r_cnt == 4'd0) begin
                    w_next_state = ST_GRANT;
                end else begin
                    w_cnt_next   = r_cnt - 4'd1;
                end
            end
            ST_GRANT: begin
                if (!HRQ) begin
                    w_next_state = ST_RELEASE;
                    w_cnt_next   = RELEASE_LOAD;
                end else begin
                    w_next_state = ST_GRANT;
                    w_cnt_next   = 4'd0;
                end
            end
            ST_RELEASE: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_cnt_next   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // Outputs decoded from the next state so they register in step with it.
    always_comb begin
        w_hlda_d     = 1'b0;
        w_aen_d      = 1'b0;
        w_cpu_hold_d = 1'b0;
        case (w_next_state)
            ST_IDLE: begin
                w_cpu_hold_d = 1'b0;
            end
            ST_REQ, ST_SETTLE, ST_RELEASE: begin
                w_cpu_hold_d = 1'b1;
            end
            ST_GRANT: begin
                w_cpu_hold_d = 1'b1;
                w_hlda_d     = 1'b1;
                w_aen_d      = 1'b1;
            end
            default: begin
                w_cpu_hold_d = 1'b0;
            end
        endcase
    end

    assign HLDA     = r_hlda;
    assign CPU_HOLD = r_cpu_hold;
    assign AEN      = r_aen;

`ifdef DMA_HOLD_TIMEOUT_EN
    localparam logic [15:0] GCNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_gcnt;
    logic        r_timeout;

    // Grant-length counter; held at zero outside GRANT so every grant starts fresh.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_gcnt    <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != ST_GRANT) begin
                r_gcnt <= 16'd0;
            end else if (r_gcnt != 16'hFFFF) begin
                r_gcnt <= r_gcnt + 16'd1;
            end else begin
                r_gcnt <= r_gcnt;
            end
            if ((r_state == ST_GRANT) && (r_gcnt == GCNT_LAST)) begin
                r_timeout <= 1'b1;
            end else begin
                r_timeout <= r_timeout;
            end
        end
    end

    assign TIMEOUT = r_timeout;
`else
    assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_dma_hold_arbiter.sv
// Self-checking bench for dma_hold_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a behavioural model.
module tb_dma_hold_arbiter;

    localparam int SET = 2;
    localparam int REL = 1;
    localparam int TO  = 8;
`ifdef DMA_HOLD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET;
    logic HRQ;
    logic CPU_HOLDACK;
    logic CPU_LOCK;
    logic HLDA;
    logic CPU_HOLD;
    logic AEN;
    logic TIMEOUT;

    int n_checks = 0;
    int n_fail   = 0;

    dma_hold_arbiter #(
        .SETTLE_CYCLES (SET),
        .RELEASE_CYCLES(REL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .HRQ        (HRQ),
        .CPU_HOLDACK(CPU_HOLDACK),
        .CPU_LOCK   (CPU_LOCK),
        .HLDA       (HLDA),
        .CPU_HOLD   (CPU_HOLD),
        .AEN        (AEN),
        .TIMEOUT    (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model: bus ownership described by phase counters, not states.
    bit m_req;
    bit m_grant;
    int m_settle_left;
    int m_rel_left;
    int m_gcycles;
    bit m_to;

    function automatic void model_reset();
        m_req = 0; m_grant = 0; m_settle_left = 0;
        m_rel_left = 0; m_gcycles = 0; m_to = 0;
    endfunction

    function automatic void model_edge(input bit hrq, input bit ack, input bit lock);
        if (m_rel_left > 0) begin
            m_rel_left--;
        end else if (m_grant) begin
            m_gcycles++;
            if (m_gcycles == TO) m_to = 1;
            if (!hrq) begin
                m_grant = 0;
                m_rel_left = REL + 1;
            end
        end else if (m_settle_left > 0) begin
            if (!hrq) begin
                m_settle_left = 0;
                m_rel_left = REL + 1;
            end else begin
                m_settle_left--;
                if (m_settle_left == 0) begin
                    m_grant = 1;
                    m_gcycles = 0;
                end
            end
        end else if (m_req) begin
            if (!hrq) begin
                m_req = 0;
                if (ack) m_rel_left = REL + 1;
            end else if (ack) begin
                m_req = 0;
                m_settle_left = SET;
            end
        end else if (hrq && !lock && !ack) begin
            m_req = 1;
        end
    endfunction

    function automatic bit model_hold();
        return m_req || m_grant || (m_settle_left > 0) || (m_rel_left > 0);
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, return at the following falling edge.
    task automatic step(input bit hrq, input bit ack, input bit lock);
        HRQ = hrq; CPU_HOLDACK = ack; CPU_LOCK = lock;
        @(posedge CLK);
        model_edge(hrq, ack, lock);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        HRQ = 1'b0; CPU_HOLDACK = 1'b0; CPU_LOCK = 1'b0;
        RESET = 1'b0;
        model_reset();
        #1;
        chk("rst_hold", CPU_HOLD, 1'b0);
        chk("rst_hlda", HLDA, 1'b0);
        chk("rst_aen", AEN, 1'b0);
        chk("rst_timeout", TIMEOUT, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    typedef struct {
        bit hrq;
        bit ack;
        bit lock;
        bit hold;
        bit hlda;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(input bit hrq, input bit ack, input bit lock,
                                input bit hold, input bit hlda);
        vec_t v;
        v.hrq = hrq; v.ack = ack; v.lock = lock; v.hold = hold; v.hlda = hlda;
        return v;
    endfunction

    initial begin
        bit r_hrq;
        bit r_ack;
        bit r_lock;

        // Handshake, lock/ack-drop tolerance, release, lock gating, withdrawals.
        tbl[0]  = mk(1, 0, 0, 1, 0);
        tbl[1]  = mk(1, 0, 0, 1, 0);
        tbl[2]  = mk(1, 1, 0, 1, 0);
        tbl[3]  = mk(1, 1, 1, 1, 0);
        tbl[4]  = mk(1, 0, 0, 1, 1);
        tbl[5]  = mk(1, 0, 1, 1, 1);
        tbl[6]  = mk(0, 0, 0, 1, 0);
        tbl[7]  = mk(1, 0, 0, 1, 0);
        tbl[8]  = mk(1, 0, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 1, 0);
        tbl[10] = mk(0, 0, 0, 0, 0);
        for (int i = 11; i <= 20; i++) tbl[i] = mk(1, 0, 1, 0, 0);
        tbl[21] = mk(1, 0, 0, 1, 0);
        tbl[22] = mk(1, 1, 0, 1, 0);
        tbl[23] = mk(0, 1, 0, 1, 0);
        tbl[24] = mk(0, 0, 0, 1, 0);
        tbl[25] = mk(0, 0, 0, 0, 0);
        tbl[26] = mk(1, 0, 0, 1, 0);
        tbl[27] = mk(0, 1, 0, 1, 0);
        tbl[28] = mk(0, 1, 0, 1, 0);
        tbl[29] = mk(0, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 30; i++) begin
            step(tbl[i].hrq, tbl[i].ack, tbl[i].lock);
            chk($sformatf("tbl%0d_hold", i), CPU_HOLD, tbl[i].hold);
            chk($sformatf("tbl%0d_hlda", i), HLDA, tbl[i].hlda);
            chk($sformatf("tbl%0d_aen", i), AEN, tbl[i].hlda);
            chk($sformatf("tbl%0d_timeout", i), TIMEOUT, 1'b0);
        end

        // Long grant: watchdog flag after the TO-th grant cycle, HLDA unaffected.
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        chk("to_grant_entry", HLDA, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            step(1, 1, 0);
            chk($sformatf("to_hlda_k%0d", k), HLDA, 1'b1);
            chk($sformatf("to_flag_k%0d", k), TIMEOUT, TO_EN && (k >= TO));
        end
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("to_idle_hold", CPU_HOLD, 1'b0);
        chk("to_sticky", TIMEOUT, TO_EN);

        // Asynchronous reset in the middle of a grant, then restart.
        do_reset();
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        chk("ar_grant", HLDA, 1'b1);
        #2;
        RESET = 1'b0;
        model_reset();
        #1;
        chk("ar_hlda", HLDA, 1'b0);
        chk("ar_aen", AEN, 1'b0);
        chk("ar_hold", CPU_HOLD, 1'b0);
        @(negedge CLK);
        HRQ = 1'b1; CPU_HOLDACK = 1'b0; CPU_LOCK = 1'b0;
        RESET = 1'b1;
        chk("ar_released_hold", CPU_HOLD, 1'b0);
        step(1, 0, 0);
        chk("ar_first_hold", CPU_HOLD, 1'b1);

        // Randomized traffic against the model.
        do_reset();
        r_hrq = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) == 0) r_hrq = !r_hrq;
            if (model_hold()) r_ack = ($urandom_range(0, 7) < 6);
            else              r_ack = ($urandom_range(0, 7) == 0);
            r_lock = ($urandom_range(0, 5) == 0);
            step(r_hrq, r_ack, r_lock);
            chk("rnd_hold", CPU_HOLD, model_hold());
            chk("rnd_hlda", HLDA, m_grant);
            chk("rnd_aen", AEN, m_grant);
            chk("rnd_timeout", TIMEOUT, TO_EN && m_to);
            chk("rnd_hlda_implies_hold", HLDA && !CPU_HOLD, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
